// File: rtl/instr_mem_ld.sv
// Instruction memory with a program-load phase followed by a pipelined,
// read-only fetch phase. Faulted fetches return NOP_WORD.
module instr_mem_ld #(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 128,
  parameter int                 ADDR_W   = 16,
  parameter int                 RD_LAT   = 1,
  parameter logic [DATA_W-1:0]  NOP_WORD = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  input  logic                     prog_done,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [1:0]               rsp_fault,
  output logic [$clog2(DEPTH):0]   prog_count,
  output logic                     running
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAST  = RD_LAT - 1;

  typedef enum logic {LOAD, RUN} state_t;

  state_t             state_q, state_d;
  logic               running_q, running_d;
  logic [IDX_W:0]     prog_count_q, prog_count_d;

  logic               pipe_valid_q [RD_LAT];
  logic               pipe_valid_d [RD_LAT];
  logic [1:0]         pipe_fault_q [RD_LAT];
  logic [1:0]         pipe_fault_d [RD_LAT];
  logic [DATA_W-1:0]  pipe_data_q  [RD_LAT];
  logic [DATA_W-1:0]  pipe_data_d  [RD_LAT];

  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_fault_q, rsp_fault_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic               load_wr;
  logic               accept;
  logic [31:0]        word_idx;
  logic               misaligned;
  logic               out_of_range;

  // Contents are set at elaboration and deliberately untouched by reset.
  logic [DATA_W-1:0]  mem [DEPTH] = '{default: NOP_WORD};

  assign load_wr    = (state_q == LOAD) && prog_we;
  assign accept     = req_valid && (state_q == RUN);
  assign req_ready  = (state_q == RUN);
  assign running    = running_q;
  assign prog_count = prog_count_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_fault  = rsp_fault_q;
  assign rsp_data   = rsp_data_q;

  always_comb begin
    state_d      = state_q;
    running_d    = running_q;
    prog_count_d = prog_count_q;
    if (state_q == LOAD) begin
      if (prog_we && (prog_count_q != (IDX_W+1)'(DEPTH))) begin
        prog_count_d = prog_count_q + (IDX_W+1)'(1);
      end
      if (prog_done) begin
        state_d   = RUN;
        running_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      running_q    <= 1'b0;
      prog_count_q <= '0;
    end else begin
      state_q      <= state_d;
      running_q    <= running_d;
      prog_count_q <= prog_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_wr) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    word_idx     = 32'(req_addr >> 2);
    misaligned   = |req_addr[1:0];
    out_of_range = (word_idx >= 32'(DEPTH));
  end

  // Stage 0 captures the raw read and fault code; later stages only delay it.
  always_comb begin
    pipe_valid_d[0] = accept;
    pipe_fault_d[0] = misaligned ? 2'b01 : (out_of_range ? 2'b10 : 2'b00);
    pipe_data_d[0]  = mem[word_idx[IDX_W-1:0]];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_fault_d[i] = pipe_fault_q[i-1];
      pipe_data_d[i]  = pipe_data_q[i-1];
    end
  end

  always_comb begin
    rsp_valid_d = pipe_valid_q[LAST];
    rsp_fault_d = rsp_fault_q;
    rsp_data_d  = rsp_data_q;
    if (pipe_valid_q[LAST]) begin
      rsp_fault_d = pipe_fault_q[LAST];
      rsp_data_d  = (pipe_fault_q[LAST] == 2'b00) ? pipe_data_q[LAST] : NOP_WORD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_fault_q[i] <= 2'b00;
        pipe_data_q[i]  <= NOP_WORD;
      end
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 2'b00;
      rsp_data_q  <= NOP_WORD;
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_fault_q[i] <= pipe_fault_d[i];
        pipe_data_q[i]  <= pipe_data_d[i];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_ld.sv
// Scoreboard bench for instr_mem_ld: three instances (RD_LAT 1, 2, 3) share
// one stimulus stream; a single monitor checks every response and status sample.
module tb_instr_mem_ld;

  localparam int          NDUT = 3;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        prog_we   = 1'b0;
  logic [6:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        prog_done = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr  = '0;

  logic [NDUT-1:0]       req_ready_w, rsp_valid_w, running_w;
  logic [NDUT-1:0][31:0] rsp_data_w;
  logic [NDUT-1:0][1:0]  rsp_fault_w;
  logic [NDUT-1:0][7:0]  prog_count_w;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    instr_mem_ld #(
      .DATA_W(32), .DEPTH(128), .ADDR_W(16), .RD_LAT(g + 1), .NOP_WORD(NOP)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .prog_done (prog_done),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready_w[g]),
      .rsp_valid (rsp_valid_w[g]),
      .rsp_data  (rsp_data_w[g]),
      .rsp_fault (rsp_fault_w[g]),
      .prog_count(prog_count_w[g]),
      .running   (running_w[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  fault;
    int          acc;
    int          epoch;
  } rsp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  rsp_t exp_q[$];
  chk_t chk_q[$];

  int cyc = 0;
  int epoch = 0;
  bit tb_done = 1'b0;
  bit running_m = 1'b0;
  int checks = 0;
  int errors = 0;
  int cptr = 0;
  int ptr [NDUT];
  rsp_t e;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: sole owner of the counters; compares posted status samples and
  // every response against the expected queue, including arrival cycle.
  always @(posedge clk) begin
    #1;
    while (cptr < chk_q.size()) begin
      checks++;
      if (chk_q[cptr].act !== chk_q[cptr].exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h, expected %h", chk_q[cptr].name, chk_q[cptr].act, chk_q[cptr].exp);
      end
      cptr++;
    end
    for (int g = 0; g < NDUT; g++) begin
      while (ptr[g] < exp_q.size() && exp_q[ptr[g]].epoch != epoch) ptr[g]++;
      if (rsp_valid_w[g]) begin
        checks++;
        if (ptr[g] >= exp_q.size()) begin
          errors++;
          $display("[TB] FAIL unexpected rsp dut%0d: got data=%h fault=%b at cyc %0d, expected no response",
                   g, rsp_data_w[g], rsp_fault_w[g], cyc);
        end else begin
          e = exp_q[ptr[g]];
          ptr[g]++;
          if (rsp_data_w[g] !== e.data || rsp_fault_w[g] !== e.fault || cyc != e.acc + g + 1) begin
            errors++;
            $display("[TB] FAIL rsp dut%0d: got data=%h fault=%b cyc=%0d, expected data=%h fault=%b cyc=%0d",
                     g, rsp_data_w[g], rsp_fault_w[g], cyc, e.data, e.fault, e.acc + g + 1);
          end
        end
      end else if (ptr[g] < exp_q.size() && exp_q[ptr[g]].acc + g + 1 <= cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing rsp dut%0d: got none at cyc %0d, expected data=%h fault=%b",
                 g, cyc, exp_q[ptr[g]].data, exp_q[ptr[g]].fault);
        ptr[g]++;
      end
    end
    if (tb_done || cyc > 5000) begin
      if (!tb_done) begin
        checks++;
        errors++;
        $display("[TB] FAIL timeout: got cyc %0d, expected completion before 5000", cyc);
      end
      for (int g = 0; g < NDUT; g++) begin
        checks++;
        if (ptr[g] != exp_q.size()) begin
          errors++;
          $display("[TB] FAIL drain dut%0d: got %0d outstanding, expected 0", g, exp_q.size() - ptr[g]);
        end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_q.push_back('{name, act, exp});
  endtask

  // Drives one cycle of inputs; fetches issued while the bench believes the
  // block is running enqueue the hand-computed response.
  task automatic applyStimulus(input logic we, input logic [6:0] waddr, input logic [31:0] wdata,
                               input logic done, input logic rv, input logic [15:0] raddr,
                               input logic [31:0] edata, input logic [1:0] efault);
    @(negedge clk);
    prog_we   = we;
    prog_addr = waddr;
    prog_data = wdata;
    prog_done = done;
    req_valid = rv;
    req_addr  = raddr;
    if (rv) begin
      for (int g = 0; g < NDUT; g++)
        checkOutput($sformatf("req_ready dut%0d", g), 32'(req_ready_w[g]), 32'(running_m));
      if (running_m) exp_q.push_back('{edata, efault, cyc + 1, epoch});
    end
    if (!running_m && done) running_m = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 2'b00);
  endtask

  task automatic loadWord(input logic [6:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 1'b0, '0, '0, 2'b00);
  endtask

  task automatic pulseDone();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 2'b00);
  endtask

  task automatic fetch(input logic [15:0] a, input logic [31:0] d, input logic [1:0] f);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, a, d, f);
  endtask

  task automatic checkState(input logic run, input int cnt);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("running dut%0d", g), 32'(running_w[g]), 32'(run));
      checkOutput($sformatf("prog_count dut%0d", g), 32'(prog_count_w[g]), 32'(cnt));
    end
  endtask

  task automatic enterReset();
    @(negedge clk);
    rst_n     = 1'b0;
    prog_we   = 1'b0;
    prog_done = 1'b0;
    req_valid = 1'b0;
    epoch++;
    running_m = 1'b0;
  endtask

  task automatic doReset(input int n);
    enterReset();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] prog_tbl [10] = '{32'h10000293, 32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213,
                                 32'h00500293, 32'h00600313, 32'h00700393, 32'h00800413, 32'h00900493};

  initial begin
    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("reset running dut%0d", g),   32'(running_w[g]),    32'd0);
      checkOutput($sformatf("reset req_ready dut%0d", g), 32'(req_ready_w[g]),  32'd0);
      checkOutput($sformatf("reset rsp_valid dut%0d", g), 32'(rsp_valid_w[g]),  32'd0);
      checkOutput($sformatf("reset rsp_fault dut%0d", g), 32'(rsp_fault_w[g]),  32'd0);
      checkOutput($sformatf("reset rsp_data dut%0d", g),  rsp_data_w[g],       NOP);
      checkOutput($sformatf("reset prog_count dut%0d", g), 32'(prog_count_w[g]), 32'd0);
    end
    rst_n = 1'b1;

    // Fetch in LOAD: not accepted, no response.
    fetch(16'h0000, NOP, 2'b00);
    idle(5);

    // Program load then RUN.
    for (int i = 0; i < 10; i++) loadWord(7'(i), prog_tbl[i]);
    pulseDone();
    idle(1);
    checkState(1'b1, 10);

    fetch(16'h0000, 32'h10000293, 2'b00);
    idle(5);

    // Back-to-back fetches.
    fetch(16'h0000, 32'h10000293, 2'b00);
    fetch(16'h0004, 32'h00100093, 2'b00);
    fetch(16'h0008, 32'h00200113, 2'b00);
    idle(5);

    // Faults and boundaries.
    fetch(16'h0006, NOP, 2'b01);
    fetch(16'h0200, NOP, 2'b10);
    fetch(16'h0202, NOP, 2'b01);
    fetch(16'h0024, 32'h00900493, 2'b00);
    fetch(16'h0028, NOP, 2'b00);
    fetch(16'h01FC, NOP, 2'b00);
    idle(5);

    // Writes in RUN are ignored.
    applyStimulus(1'b1, 7'd0, 32'hFFFFFFFF, 1'b0, 1'b0, '0, '0, 2'b00);
    fetch(16'h0000, 32'h10000293, 2'b00);
    idle(5);
    checkState(1'b1, 10);

    // Reset with a fetch in flight: response must be discarded.
    fetch(16'h0004, 32'h00100093, 2'b00);
    enterReset();
    #1;
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("flush rsp_valid dut%0d", g), 32'(rsp_valid_w[g]), 32'd0);
      checkOutput($sformatf("flush rsp_data dut%0d", g), rsp_data_w[g], NOP);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    checkState(1'b0, 0);

    // Memory survives reset.
    pulseDone();
    fetch(16'h0000, 32'h10000293, 2'b00);
    fetch(16'h0014, 32'h00500293, 2'b00);
    idle(5);

    // Write and done in the same cycle.
    doReset(2);
    applyStimulus(1'b1, 7'd5, 32'h00a00393, 1'b1, 1'b0, '0, '0, 2'b00);
    idle(1);
    checkState(1'b1, 1);
    fetch(16'h0014, 32'h00a00393, 2'b00);
    fetch(16'h0000, 32'h10000293, 2'b00);
    idle(5);

    // Count saturation over 129 writes.
    doReset(2);
    for (int i = 0; i < 129; i++) loadWord(7'(i % 128), 32'hA0000000 + 32'(i));
    idle(1);
    checkState(1'b0, 128);
    pulseDone();
    fetch(16'h0000, 32'hA0000080, 2'b00);
    fetch(16'h01FC, 32'hA000007F, 2'b00);
    fetch(16'h0014, 32'hA0000005, 2'b00);
    idle(8);

    tb_done = 1'b1;
  end

endmodule
